full_adder_bist: RTL and testbench

Built-in self-test controller for a 1-bit full adder. It drives all eight {a,b,c} input combinations into a full adder under test, samples the sum/carry response, and compares each against a golden model. It reports pass/fail, a failure count and the first failing vector. It is the synthesizable response-checking counterpart to the adder's stimulus bench, and it sits beside the `full_adder` instance in self-test builds.

---
 rtl/full_adder_bist_pkg.sv | 18 +
 rtl/full_adder_ref.sv | 14 +
 rtl/full_adder_bist.sv | 136 +++++++++++++
 tb/tb_full_adder_bist.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_bist_pkg.sv
// Shared types and sizing for the full-adder self-test controller.
package full_adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;
    localparam int CNT_W       = 4;
    localparam int WAIT_W      = 4;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/full_adder_ref.sv
// Golden 1-bit full adder, written from the truth equations rather than
// from the adder under test so a shared netlist bug cannot mask itself.
module full_adder_ref (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic exp_sum_o,
    output logic exp_carry_o
);

    assign exp_sum_o   = a_i ^ b_i ^ c_i;
    assign exp_carry_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);

endmodule

// File: rtl/full_adder_bist.sv
// Self-test controller: walks all eight {a,b,c} vectors through the adder
// under test, compares the response with a golden model and records the
// failure count and the first failing vector.
//
// state | meaning
// IDLE  | waiting for start, operands parked at 0
// APPLY | vector idx driven, letting the adder settle for SETTLE cycles
// CHECK | response sampled and compared against the golden model
// DONE  | run finished, results held until the next start or rst
module full_adder_bist
    import full_adder_bist_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             sum_in,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [VEC_W-1:0] first_fail_vec
);

    localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE - 1);

    state_e              state_q, state_d;
    logic [VEC_W-1:0]    idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    fail_q, fail_d;
    logic [VEC_W-1:0]    first_q, first_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic [VEC_W-1:0]    vec;
    logic                exp_sum;
    logic                exp_carry;
    logic                mismatch;

    // idx is left at 7 after the last vector, so DONE naturally shows 3'b111.
    assign vec       = (state_q == IDLE) ? '0 : idx_q;
    assign {a, b, c} = vec;

    full_adder_ref u_ref (
        .a_i         (a),
        .b_i         (b),
        .c_i         (c),
        .exp_sum_o   (exp_sum),
        .exp_carry_o (exp_carry)
    );

    // One count per vector regardless of whether sum, carry or both are wrong.
    assign mismatch = (sum_in != exp_sum) || (carry_in != exp_carry);

    assign busy           = (state_q == APPLY) || (state_q == CHECK);
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_q;
    assign first_fail_vec = first_q;

    // Next-state and result-update logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        fail_d  = fail_q;
        first_d = first_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    wait_d  = '0;
                    fail_d  = '0;
                    first_d = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    fail_d = fail_q + 4'd1;
                    if (fail_q == '0) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == LAST_VEC) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (fail_d == '0);
                end else begin
                    idx_d   = idx_q + 3'd1;
                    wait_d  = '0;
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            fail_q  <= '0;
            first_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            fail_q  <= fail_d;
            first_q <= first_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

endmodule

// File: tb/tb_full_adder_bist.sv
// Bench for full_adder_bist: two controllers (SETTLE=1 and SETTLE=3) share
// start/rst, each checking its own fault-injectable adder model.
module tb_full_adder_bist;

    logic clk = 1'b0;
    logic rst;
    logic start;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_w[2], b_w[2], c_w[2], sum_w[2], carry_w[2];
    logic       busy_w[2], done_w[2], pass_w[2];
    logic [3:0] fc_w[2];
    logic [2:0] ffv_w[2];

    // 0: correct, 1: carry stuck at 0, 2: sum inverted, 3: per-vector flips
    int         mode[2];
    logic [7:0] sflip[2];
    logic [7:0] cflip[2];

    int total = 0;
    int bad   = 0;
    int t0    = 0;

    typedef struct {
        int fc;
        int ffv;
        int pass;
        int t0;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [1:0] done_prev = 2'b00;

    function automatic logic [1:0] dut_resp(int m, logic [7:0] sf, logic [7:0] cf, logic [2:0] v);
        int   n;
        logic s, cy;
        n  = int'(v[2]) + int'(v[1]) + int'(v[0]);
        s  = (n % 2) == 1;
        cy = n >= 2;
        case (m)
            1: cy = 1'b0;
            2: s  = ~s;
            3: begin
                s  = s ^ sf[v];
                cy = cy ^ cf[v];
            end
            default: ;
        endcase
        return {cy, s};
    endfunction

    assign {carry_w[0], sum_w[0]} = dut_resp(mode[0], sflip[0], cflip[0], {a_w[0], b_w[0], c_w[0]});
    assign {carry_w[1], sum_w[1]} = dut_resp(mode[1], sflip[1], cflip[1], {a_w[1], b_w[1], c_w[1]});

    full_adder_bist #(.SETTLE(1)) u_dut_s1 (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .a              (a_w[0]),
        .b              (b_w[0]),
        .c              (c_w[0]),
        .sum_in         (sum_w[0]),
        .carry_in       (carry_w[0]),
        .busy           (busy_w[0]),
        .done           (done_w[0]),
        .pass           (pass_w[0]),
        .fail_count     (fc_w[0]),
        .first_fail_vec (ffv_w[0])
    );

    full_adder_bist #(.SETTLE(3)) u_dut_s3 (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .a              (a_w[1]),
        .b              (b_w[1]),
        .c              (c_w[1]),
        .sum_in         (sum_w[1]),
        .carry_in       (carry_w[1]),
        .busy           (busy_w[1]),
        .done           (done_w[1]),
        .pass           (pass_w[1]),
        .fail_count     (fc_w[1]),
        .first_fail_vec (ffv_w[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Arithmetic reference: count vectors whose faulty response differs from a+b+c.
    function automatic exp_t model(int m, logic [7:0] sf, logic [7:0] cf, int ts);
        exp_t e;
        int   n;
        logic [1:0] gold, got;
        e.fc  = 0;
        e.ffv = 0;
        for (int v = 0; v < 8; v++) begin
            n    = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
            gold = 2'(n);
            got  = dut_resp(m, sf, cf, 3'(v));
            if (got != gold) begin
                if (e.fc == 0) e.ffv = v;
                e.fc++;
            end
        end
        e.pass = (e.fc == 0) ? 1 : 0;
        e.t0   = ts;
        return e;
    endfunction

    // Scoreboard monitor: pops an expectation each time a run completes.
    always @(negedge clk) begin
        exp_t e;
        int   have;
        for (int i = 0; i < 2; i++) begin
            if (done_w[i] === 1'b1 && !done_prev[i]) begin
                if (i == 0) begin
                    have = q0.size();
                    if (have > 0) e = q0.pop_front();
                end else begin
                    have = q1.size();
                    if (have > 0) e = q1.pop_front();
                end
                if (have == 0) begin
                    chk($sformatf("spurious_done[%0d]", i), 1, 0);
                end else begin
                    chk($sformatf("fail_count[%0d]", i), int'(fc_w[i]), e.fc);
                    chk($sformatf("first_fail_vec[%0d]", i), int'(ffv_w[i]), e.ffv);
                    chk($sformatf("pass[%0d]", i), int'(pass_w[i]), e.pass);
                    chk($sformatf("run_length[%0d]", i), cyc - e.t0, (i == 0) ? 17 : 33);
                    chk($sformatf("busy_at_done[%0d]", i), int'(busy_w[i]), 0);
                end
            end
            done_prev[i] = (done_w[i] === 1'b1);
        end
    end

    task automatic set_fault(input int i, input int m);
        mode[i]  = m;
        sflip[i] = (m == 3) ? 8'($urandom) : 8'h00;
        cflip[i] = (m == 3) ? 8'($urandom) : 8'h00;
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_abc[%0d]", tag, i), int'({a_w[i], b_w[i], c_w[i]}), 0);
            chk($sformatf("%s_busy[%0d]", tag, i), int'(busy_w[i]), 0);
            chk($sformatf("%s_done[%0d]", tag, i), int'(done_w[i]), 0);
            chk($sformatf("%s_pass[%0d]", tag, i), int'(pass_w[i]), 0);
            chk($sformatf("%s_fc[%0d]", tag, i), int'(fc_w[i]), 0);
            chk($sformatf("%s_ffv[%0d]", tag, i), int'(ffv_w[i]), 0);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        t0    = cyc;
        start = 1'b1;
        q0.push_back(model(mode[0], sflip[0], cflip[0], t0));
        q1.push_back(model(mode[1], sflip[1], cflip[1], t0));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("start_busy[%0d]", i), int'(busy_w[i]), 1);
            chk($sformatf("start_vec0[%0d]", i), int'({a_w[i], b_w[i], c_w[i]}), 0);
            chk($sformatf("start_done_clr[%0d]", i), int'(done_w[i]), 0);
            chk($sformatf("start_pass_clr[%0d]", i), int'(pass_w[i]), 0);
            chk($sformatf("start_fc_clr[%0d]", i), int'(fc_w[i]), 0);
            chk($sformatf("start_ffv_clr[%0d]", i), int'(ffv_w[i]), 0);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!(done_w[0] === 1'b1 && done_w[1] === 1'b1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("run_timeout", 0, 1);
    endtask

    task automatic run(input int m0, input int m1);
        set_fault(0, m0);
        set_fault(1, m1);
        pulse_start();
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_fault(0, 0);
        set_fault(1, 0);
        repeat (3) @(posedge clk);
        // start during reset must be ignored
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Correct adder, then the two named fault patterns.
        run(0, 0);
        run(1, 1);
        run(2, 2);

        // A start pulse mid-run must not disturb the run length or results.
        set_fault(0, 0);
        set_fault(1, 0);
        pulse_start();
        repeat (6) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // Faulty run followed by a corrected run started from DONE.
        run(3, 1);
        run(0, 0);

        // Reset while the SETTLE=1 controller drives vector 4.
        set_fault(0, 0);
        set_fault(1, 2);
        pulse_start();
        repeat (8) @(negedge clk);
        chk("vec4_before_rst", int'({a_w[0], b_w[0], c_w[0]}), 4);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("midrun_rst");
        run(0, 0);

        // Random fault patterns.
        for (int r = 0; r < 6; r++) begin
            run(($urandom_range(0, 3) == 0) ? 0 : 3, 3);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty0", q0.size(), 0);
        chk("sb_empty1", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
